// File: rtl/rnd_vec_ctrl.sv
// rnd_vec_ctrl: round-robin front end that shares one rnd_vec_gen
// between NREQ stimulus requesters and tags each vector with its id.
module rnd_vec_ctrl #(
  parameter int OUT_SIZE = 16,
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int INIT_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [2*NREQ-1:0]   req_cmd,
  output logic [NREQ-1:0]     grant,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [OUT_SIZE-1:0] rsp_data,
  output logic                busy,
  output logic                gen_init,
  output logic                gen_save,
  output logic                gen_restore,
  output logic                gen_next,
  input  logic [OUT_SIZE-1:0] gen_out
);

  localparam int CW = $clog2(INIT_LEN + 1);

  localparam logic [1:0] CMD_NEXT    = 2'b00;
  localparam logic [1:0] CMD_SAVE    = 2'b01;
  localparam logic [1:0] CMD_RESTORE = 2'b10;
  localparam logic [1:0] CMD_REINIT  = 2'b11;

  typedef enum logic [2:0] {
    PINIT, IDLE, ISSUE, WINIT, CAPT
  } state_t;

  state_t              state, nxt;
  logic [CW-1:0]       cnt, cnt_d;
  logic                cnt_done;
  logic [IDW-1:0]      rr_ptr, rr_d;
  logic [IDW-1:0]      win, rsp_id_d;
  logic [1:0]          win_cmd;
  logic                found;
  logic [NREQ-1:0]     grant_d;
  logic                rsp_valid_d, busy_d;
  logic                init_d, save_d;
  logic                restore_d, next_d;
  logic [OUT_SIZE-1:0] rsp_data_d;

  assign cnt_done = (cnt == CW'(INIT_LEN));

  // Two passes give priority rr_ptr+1 .. NREQ-1, then 0 .. rr_ptr.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    win_cmd = CMD_NEXT;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && j > int'(rr_ptr) && req_valid[j]) begin
        found   = 1'b1;
        win     = IDW'(j);
        win_cmd = req_cmd[2*j +: 2];
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!found && j <= int'(rr_ptr) && req_valid[j]) begin
        found   = 1'b1;
        win     = IDW'(j);
        win_cmd = req_cmd[2*j +: 2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= PINIT;
      cnt         <= '0;
      rr_ptr      <= IDW'(NREQ - 1);
      grant       <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_data    <= '0;
      busy        <= 1'b1;
      gen_init    <= 1'b0;
      gen_save    <= 1'b0;
      gen_restore <= 1'b0;
      gen_next    <= 1'b0;
    end else begin
      state       <= nxt;
      cnt         <= cnt_d;
      rr_ptr      <= rr_d;
      grant       <= grant_d;
      rsp_valid   <= rsp_valid_d;
      rsp_id      <= rsp_id_d;
      rsp_data    <= rsp_data_d;
      busy        <= busy_d;
      gen_init    <= init_d;
      gen_save    <= save_d;
      gen_restore <= restore_d;
      gen_next    <= next_d;
    end
  end

  // cnt counts gen_init high cycles; WINIT is entered with
  // the first one already issued at the accept edge.
  always_comb begin
    nxt   = state;
    cnt_d = cnt;
    unique case (state)
      PINIT: begin
        if (cnt_done) nxt   = IDLE;
        else          cnt_d = cnt + 1'b1;
      end
      IDLE: begin
        if (found) begin
          nxt   = (win_cmd == CMD_REINIT) ? WINIT : ISSUE;
          cnt_d = CW'(1);
        end
      end
      ISSUE: nxt = CAPT;
      WINIT: begin
        if (cnt_done) nxt   = CAPT;
        else          cnt_d = cnt + 1'b1;
      end
      CAPT:    nxt = IDLE;
      default: nxt = PINIT;
    endcase
  end

  always_comb begin
    grant_d     = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id;
    rsp_data_d  = rsp_data;
    rr_d        = rr_ptr;
    busy_d      = (nxt != IDLE);
    init_d      = 1'b0;
    save_d      = 1'b0;
    restore_d   = 1'b0;
    next_d      = 1'b0;
    unique case (state)
      PINIT: init_d = !cnt_done;
      IDLE: begin
        if (found) begin
          grant_d[win] = 1'b1;
          rsp_id_d     = win;
          rr_d         = win;
          unique case (1'b1)
            (win_cmd == CMD_NEXT):    next_d    = 1'b1;
            (win_cmd == CMD_SAVE):    save_d    = 1'b1;
            (win_cmd == CMD_RESTORE): restore_d = 1'b1;
            (win_cmd == CMD_REINIT):  init_d    = 1'b1;
            default: ;
          endcase
        end
      end
      WINIT: init_d = !cnt_done;
      CAPT: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = gen_out;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rnd_vec_ctrl.sv
// tb_rnd_vec_ctrl: directed + random bench for rnd_vec_ctrl with a
// behavioural generator stand-in and an abstract command model.
module tb_rnd_vec_ctrl;

  localparam int OUT_SIZE = 16;
  localparam int NREQ     = 4;
  localparam int IDW      = 2;
  localparam int INIT_LEN = 32;
  localparam logic [15:0] SEED = 16'hACE1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [2*NREQ-1:0]   req_cmd = '0;
  logic [NREQ-1:0]     grant;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [OUT_SIZE-1:0] rsp_data;
  logic                busy;
  logic                gen_init, gen_save, gen_restore, gen_next;
  logic [OUT_SIZE-1:0] gen_out;

  logic [15:0] gen_state = '0;
  logic [15:0] gen_snap  = '0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int          rr_m  = NREQ - 1;
  logic [15:0] cur_m = '0;
  logic [15:0] snap_m = '0;
  int          rsp_cyc[$];

  always #5 clk = ~clk;

  rnd_vec_ctrl #(
    .OUT_SIZE(OUT_SIZE), .NREQ(NREQ),
    .IDW(IDW), .INIT_LEN(INIT_LEN)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_cmd(req_cmd),
    .grant(grant), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .gen_init(gen_init),
    .gen_save(gen_save), .gen_restore(gen_restore),
    .gen_next(gen_next), .gen_out(gen_out)
  );

  function automatic logic [15:0] lfsr(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  // generator stand-in: output changes the edge after a strobe
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (gen_init)         gen_state <= SEED;
    else if (gen_next)    gen_state <= lfsr(gen_state);
    else if (gen_save)    gen_snap  <= gen_state;
    else if (gen_restore) gen_state <= gen_snap;
  end
  assign gen_out = gen_state;

  always @(negedge clk) begin
    checks++;
    assert ($onehot0({gen_init, gen_save, gen_restore, gen_next}))
    else begin
      errors++;
      $error("FAIL strobe_excl observed=%b required=at-most-one",
             {gen_init, gen_save, gen_restore, gen_next});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_cmd(input logic [1:0] c);
    case (c)
      2'd0: cur_m = lfsr(cur_m);
      2'd1: snap_m = cur_m;
      2'd2: cur_m = snap_m;
      default: cur_m = SEED;
    endcase
  endtask

  function automatic logic [3:0] strobe_of(input logic [1:0] c);
    case (c)
      2'd0: return 4'b0001;
      2'd1: return 4'b0100;
      2'd2: return 4'b0010;
      default: return 4'b1000;
    endcase
  endfunction

  // called on the negedge right after rst falls
  task automatic init_check(input string tag);
    int hi = 0;
    int ifall = -1;
    int bfall = -1;
    int rv = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (gen_init) hi++;
      if (!gen_init && ifall < 0) ifall = c;
      if (!busy && bfall < 0) bfall = c;
      if (rsp_valid) rv++;
    end
    chk({tag, "_init_cycles"}, hi, INIT_LEN);
    chk({tag, "_init_fall"}, ifall, INIT_LEN);
    chk({tag, "_busy_fall"}, bfall, INIT_LEN);
    chk({tag, "_no_rsp"}, rv, 0);
    cur_m = SEED;
    rr_m  = NREQ - 1;
  endtask

  // raise mask with per-requester cmds; serve all, checking each
  task automatic run(input logic [3:0] mask, input logic [7:0] cmds);
    logic [3:0] pend;
    pend      = mask;
    req_cmd   = cmds;
    req_valid = mask;
    while (pend != 0) begin
      int w;
      int lat;
      int ihi;
      int rv;
      logic [1:0] c;
      logic [1:0] idx;
      logic [3:0] eg;
      logic hit;
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        idx = 2'((rr_m + k) % NREQ);
        if (w < 0 && pend[idx]) w = int'(idx);
      end
      hit = 1'b0;
      for (int t = 0; t < 100 && !hit; t++) begin
        @(negedge clk);
        hit = (grant != 0);
      end
      if (!hit) begin
        chk("grant_timeout", 0, 1);
        req_valid = '0;
        return;
      end
      eg = '0;
      eg[w] = 1'b1;
      chk("grant", grant, eg);
      c = cmds[2*w +: 2];
      chk("strobe", {gen_init, gen_save, gen_restore, gen_next},
          strobe_of(c));
      pend[w]      = 1'b0;
      req_valid[w] = 1'b0;
      rr_m         = w;
      model_cmd(c);
      lat = (c == 2'd3) ? INIT_LEN + 1 : 2;
      ihi = gen_init ? 1 : 0;
      rv  = 0;
      for (int t = 1; t < lat; t++) begin
        @(negedge clk);
        if (gen_init) ihi++;
        if (rsp_valid) rv++;
      end
      @(negedge clk);
      chk("init_hold", ihi, (c == 2'd3) ? INIT_LEN : 0);
      chk("rsp_early", rv, 0);
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id", rsp_id, w);
      chk("rsp_data", rsp_data, cur_m);
      rsp_cyc.push_back(cyc);
    end
  endtask

  initial begin
    logic [15:0] v0;
    logic [15:0] n1;
    logic hit;

    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 1);
    chk("rst_strobes", {gen_init, gen_save, gen_restore, gen_next}, 0);

    // T1
    rst = 1'b0;
    init_check("t1");

    // T3 then T2: four-way NEXT from rr_ptr=3, then req0 again
    rsp_cyc.delete();
    run(4'b1111, 8'h00);
    run(4'b0001, 8'h00);
    for (int i = 0; i + 1 < rsp_cyc.size(); i++)
      chk("rsp_spacing", rsp_cyc[i+1] - rsp_cyc[i], 3);

    // T4: shared snapshot
    run(4'b0001, 8'b00_00_00_01);
    v0 = cur_m;
    run(4'b0010, 8'h00);
    n1 = cur_m;
    run(4'b0010, 8'h00);
    run(4'b0010, 8'h00);
    run(4'b0100, 8'b00_10_00_00);
    chk("t4_restore", rsp_data, v0);
    run(4'b0001, 8'h00);
    chk("t4_replay", rsp_data, n1);

    // T5
    run(4'b1000, 8'b11_00_00_00);
    chk("t5_reinit_vec", rsp_data, SEED);

    // T6: reset in the middle of REINIT
    req_cmd   = 8'b00_00_11_00;
    req_valid = 4'b0010;
    hit = 1'b0;
    for (int t = 0; t < 100 && !hit; t++) begin
      @(negedge clk);
      hit = (grant != 0);
    end
    chk("t6_grant", grant, 4'b0010);
    req_valid = '0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_grant_rst", grant, 0);
    chk("t6_rsp_rst", rsp_valid, 0);
    chk("t6_strobes_rst",
        {gen_init, gen_save, gen_restore, gen_next}, 0);
    chk("t6_busy_rst", busy, 1);
    rst = 1'b0;
    init_check("t6");

    // random contention and command mixes
    for (int n = 0; n < 15; n++) begin
      logic [3:0] m;
      logic [7:0] cm;
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        int r;
        r = $urandom_range(0, 9);
        cm[2*i +: 2] = (r < 4) ? 2'd0 : (r < 6) ? 2'd1 :
                       (r < 8) ? 2'd2 : (r == 8) ? 2'd3 : 2'd0;
      end
      run(m, cm);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
